imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that writes a program image into the instruction BRAM (`bram32`) write port while the core is held stalled. It receives the image as a byte stream with a valid/ready handshake from a host-side link such as a UART receiver. The stream is a 32-bit word count followed by that many little-endian instruction words. The loader replaces the bench-driven BRAM initialisation: the core's PC only advances after `done`.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: byte-address width of the BRAM write port. Capacity is MAX_WORDS = 2^(ADDR_WIDTH-2) words.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request to begin a load. Honoured only in IDLE, DONE or ERR.
- `s_data` in 8: stream byte.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: loader accepts a byte. Transfer occurs when `s_valid && s_ready` at a rising edge.
- `w_addr` out ADDR_WIDTH: BRAM byte write address, 4-byte aligned.
- `w_dat` out 32: BRAM write data.
- `w_enb` out 1: BRAM write enable, one-cycle pulse per word.
- `byte_enb` out 4: 4'b1111 while `w_enb`=1, otherwise 4'b0000.
- `core_stall` out 1: drives the PC `stall` input. It is high from reset until `done`.
- `done` out 1: level, program fully written.
- `error` out 1: level, header word count exceeds MAX_WORDS.
- `words_written` out ADDR_WIDTH-1: count of words committed in the current load.

## Operation
- States: IDLE, LEN, DATA, WRITE, DONE, ERR.
- **IDLE**
  - `s_ready`=0, `core_stall`=1.
  - `start` -> LEN; clear the byte counter, word index and `words_written`.
- **LEN**
  - `s_ready`=1. Accept 4 bytes, little-endian: the first byte goes to len[7:0].
  - On the 4th accepted byte:
    - len==0 -> DONE.
    - len>MAX_WORDS -> ERR.
    - otherwise -> DATA.
- **DATA**
  - `s_ready`=1. Accept 4 bytes into a shift/assemble register: the first byte goes to [7:0], the fourth to [31:24].
  - On the 4th byte -> WRITE.
- **WRITE** (exactly one cycle)
  - Outputs: `s_ready`=0, `w_enb`=1, `byte_enb`=4'b1111, `w_addr`=index*4, `w_dat`=assembled word.
  - Then increment index and `words_written`.
  - If index+1==len -> DONE, else -> DATA.
- **DONE**
  - `done`=1, `core_stall`=0, `s_ready`=0.
  - `start` -> LEN: clear `done`, reassert `core_stall`, counters reset.
- **ERR**
  - `error`=1, `core_stall`=1, `s_ready`=0. No BRAM writes occur.
  - `start` -> LEN: clears `error`.
- Bytes presented while `s_ready`=0 are not consumed. The loader never drops or duplicates a byte.
- `start` in LEN, DATA or WRITE is ignored.
- The index width is ADDR_WIDTH-2. The address is {index, 2'b00}, and there is no wrap because len<=MAX_WORDS. len==MAX_WORDS is legal and ends at address 2^ADDR_WIDTH-4.

## Timing
- All outputs are registered.
- Reset values:
  - `s_ready`=0, `w_enb`=0, `byte_enb`=0, `w_addr`=0, `w_dat`=0.
  - `core_stall`=1, `done`=0, `error`=0, `words_written`=0.
  - State IDLE.
- `start` sampled at edge T -> `s_ready`=1 from T+1.
- 4th data byte accepted at edge T -> `w_enb`=1 during cycle T+1 to T+2. The BRAM captures the word at edge T+2. `s_ready` returns to 1 in cycle T+2 if more words remain.
- Last write at edge T -> `done`=1 and `core_stall`=0 from T+1. The PC starts fetching `BOOT_ADDR` on the following edge.
- Zero-length image: 4th header byte at T -> `done`=1 from T+1.
- Throughput with `s_valid` held high: 5 cycles per word (4 accept cycles plus 1 WRITE cycle).
- `rst` high at any edge, in any state, forces the reset values on the next cycle. A partially assembled word is discarded and never written.

## Test plan
- **Nominal load.** Load len=4 with words 0x00500093, 0x00300113, 0x002081B3, 0x00000013, `s_valid` continuous. Required:
  - Exactly 4 `w_enb` pulses, at `w_addr` 0x000, 0x004, 0x008, 0x00C with those data values, `byte_enb`=4'b1111.
  - `done`=1 and `words_written`=4.
  - PC+`bram32` then read the four words back in order.
- **Irregular source.** Same image, with `s_valid` toggling pseudo-randomly (gaps of 0–3 cycles). Required: identical write sequence, no extra `w_enb`, `s_ready`=0 observed during every WRITE cycle.
- **Zero length.** Header len=0. Required: no `w_enb`, `done`=1 one cycle after the 4th header byte, `core_stall`=0.
- **Oversize header.** Header len=257 with ADDR_WIDTH=10. Required: `error`=1, `s_ready`=0, no writes, `core_stall`=1. A following `start` plus a valid len=1 image -> one write at 0x000, then `done`=1.
- **Reset mid-word.** Assert `rst` after 2 bytes of word 2. Required: every output at its reset value the next cycle, no write to 0x008. A new `start` reloads from address 0x000.
- **Start while busy.** Pulse `start` during DATA. Required: ignored, load completes normally. Pulse `start` in DONE. Required: `core_stall` reasserted, `done` cleared, `s_ready`=1 next cycle.

Source files
------------

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module  : imem_loader_if
// Purpose : Byte-stream handshake and BRAM write-port bundle for imem_loader.
// Rev     : 1.0  initial release
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]            s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [31:0]           w_dat;
    logic                  w_enb;
    logic [3:0]            byte_enb;

    // master: the loader (consumes the stream, drives the BRAM write port)
    modport master (
        input  s_data, s_valid,
        output s_ready, w_addr, w_dat, w_enb, byte_enb
    );

    // slave: host link and BRAM side
    modport slave (
        output s_data, s_valid,
        input  s_ready, w_addr, w_dat, w_enb, byte_enb
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module  : imem_loader
// Purpose : Boot loader writing a length-prefixed little-endian word image
//           from a byte stream into the instruction BRAM, core held stalled.
// Rev     : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  start,
    imem_loader_if.master              bus,
    output logic                       core_stall,
    output logic                       done,
    output logic                       error,
    output logic [ADDR_WIDTH-2:0]      words_written
);

    localparam logic [31:0]           MAX_WORDS = 32'd1 << (ADDR_WIDTH - 2);
    localparam logic [ADDR_WIDTH-2:0] WW_ONE    = 1;
    localparam logic [ADDR_WIDTH-3:0] IDX_ONE   = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [31:0]           len_q, len_d;
    logic [23:0]           word_q, word_d;
    logic [ADDR_WIDTH-3:0] index_q, index_d;
    logic [ADDR_WIDTH-2:0] ww_q, ww_d;

    logic                  s_ready_q, s_ready_d;
    logic                  w_enb_q, w_enb_d;
    logic [3:0]            byte_enb_q, byte_enb_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [31:0]           w_dat_q, w_dat_d;
    logic                  core_stall_q, core_stall_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  w_xfer;
    logic [31:0]           w_len_full;
    logic [31:0]           w_word_full;
    logic [ADDR_WIDTH-2:0] w_ww_inc;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        word_d     = word_q;
        index_d    = index_q;
        ww_d       = ww_q;
        w_addr_d   = w_addr_q;
        w_dat_d    = w_dat_q;

        w_xfer      = bus.s_valid && s_ready_q;
        // Bytes enter at the top so the first byte ends up in [7:0].
        w_len_full  = {bus.s_data, len_q[31:8]};
        w_word_full = {bus.s_data, word_q};
        w_ww_inc    = ww_q + WW_ONE;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN;
                    byte_cnt_d = 2'd0;
                    index_d    = '0;
                    ww_d       = '0;
                end
            end
            S_LEN: begin
                if (w_xfer) begin
                    len_d      = w_len_full;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (w_len_full == 32'd0)           state_d = S_DONE;
                        else if (w_len_full > MAX_WORDS)   state_d = S_ERR;
                        else                               state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    word_d     = w_word_full[31:8];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d  = S_WRITE;
                        w_addr_d = {index_q, 2'b00};
                        w_dat_d  = w_word_full;
                    end
                end
            end
            S_WRITE: begin
                index_d = index_q + IDX_ONE;
                ww_d    = w_ww_inc;
                if ({{(33 - ADDR_WIDTH){1'b0}}, w_ww_inc} == len_q) state_d = S_DONE;
                else                                                state_d = S_DATA;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        s_ready_d    = (state_d == S_LEN) || (state_d == S_DATA);
        w_enb_d      = (state_d == S_WRITE);
        byte_enb_d   = w_enb_d ? 4'b1111 : 4'b0000;
        core_stall_d = (state_d != S_DONE);
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= 2'd0;
            len_q        <= 32'd0;
            word_q       <= 24'd0;
            index_q      <= '0;
            ww_q         <= '0;
            s_ready_q    <= 1'b0;
            w_enb_q      <= 1'b0;
            byte_enb_q   <= 4'b0000;
            w_addr_q     <= '0;
            w_dat_q      <= 32'd0;
            core_stall_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            len_q        <= len_d;
            word_q       <= word_d;
            index_q      <= index_d;
            ww_q         <= ww_d;
            s_ready_q    <= s_ready_d;
            w_enb_q      <= w_enb_d;
            byte_enb_q   <= byte_enb_d;
            w_addr_q     <= w_addr_d;
            w_dat_q      <= w_dat_d;
            core_stall_q <= core_stall_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.w_enb      = w_enb_q;
    assign bus.byte_enb   = byte_enb_q;
    assign bus.w_addr     = w_addr_q;
    assign bus.w_dat      = w_dat_q;
    assign core_stall     = core_stall_q;
    assign done           = done_q;
    assign error          = error_q;
    assign words_written  = ww_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_loader
// Purpose : Randomized self-checking bench for imem_loader against a
//           queue-based model of the expected BRAM write sequence.
// Rev     : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    localparam int AW        = 10;
    localparam int MAX_WORDS = 1 << (AW - 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          core_stall, done, error;
    logic [AW-2:0] words_written;

    imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .bus           (bus),
        .core_stall    (core_stall),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] words_q[$];
    logic [31:0] got_a[$];
    logic [31:0] got_d[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Capture every BRAM write pulse and check the write-cycle qualifiers.
    always @(negedge clk) begin
        if (bus.w_enb) begin
            got_a.push_back(32'(bus.w_addr));
            got_d.push_back(bus.w_dat);
            check("byte_enb_in_write", bus.byte_enb, 4'b1111);
            check("s_ready_in_write", bus.s_ready, 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int gap;
        int waited;
        bit acc;
        gap    = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        waited = 0;
        bus.s_valid = 1'b0;
        repeat (gap) tick();
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        do begin
            acc = bus.s_ready;
            tick();
            waited++;
        end while (!acc && waited < 500);
        bus.s_valid = 1'b0;
        if (!acc) check("accept_timeout", acc, 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], maxgap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fill_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    // Expected: word i of a legal image lands at byte address 4*i.
    task automatic compare_writes(input int n_exp);
        check("num_writes", got_a.size(), n_exp);
        for (int i = 0; i < n_exp && i < got_a.size(); i++) begin
            check("w_addr", got_a[i], 32'(i * 4));
            check("w_dat", got_d[i], words_q[i]);
        end
    endtask

    task automatic run_load(input logic [31:0] len, input int maxgap, input bit mid_start);
        int n_exp;
        got_a.delete();
        got_d.delete();
        pulse_start();
        check("start_s_ready", bus.s_ready, 1'b1);
        check("start_core_stall", core_stall, 1'b1);
        check("start_done", done, 1'b0);
        check("start_error", error, 1'b0);
        check("start_words_written", words_written, 0);
        send_word(len, maxgap);
        if (len == 0) begin
            check("zero_done", done, 1'b1);
            check("zero_core_stall", core_stall, 1'b0);
            check("zero_s_ready", bus.s_ready, 1'b0);
            n_exp = 0;
        end else if (len > MAX_WORDS) begin
            check("err_error", error, 1'b1);
            check("err_s_ready", bus.s_ready, 1'b0);
            check("err_core_stall", core_stall, 1'b1);
            repeat (6) tick();
            check("err_error_held", error, 1'b1);
            n_exp = 0;
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (mid_start && i == int'(len) / 2 && b == 2) pulse_start();
                    send_byte(words_q[i][8*b +: 8], maxgap);
                end
            end
            check("last_w_enb", bus.w_enb, 1'b1);
            tick();
            check("done_after_last", done, 1'b1);
            check("core_stall_after_last", core_stall, 1'b0);
            check("words_written", words_written, len);
            check("s_ready_after_last", bus.s_ready, 1'b0);
            n_exp = int'(len);
        end
        repeat (3) tick();
        compare_writes(n_exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (3) tick();
        check("rst_s_ready", bus.s_ready, 1'b0);
        check("rst_w_enb", bus.w_enb, 1'b0);
        check("rst_core_stall", core_stall, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_words_written", words_written, 0);
        rst = 1'b0;
        tick();

        // Nominal image, continuous stream, then the same with gaps.
        words_q = '{32'h00500093, 32'h00300113, 32'h002081B3, 32'h00000013};
        run_load(32'd4, 0, 1'b0);
        run_load(32'd4, 3, 1'b0);

        // Zero length, oversize header, recovery with a single word.
        run_load(32'd0, 2, 1'b0);
        run_load(32'd257, 1, 1'b0);
        fill_words(1);
        run_load(32'd1, 2, 1'b0);

        // Start pulsed while assembling a data word is ignored.
        fill_words(6);
        run_load(32'd6, 2, 1'b1);

        // Reset after two bytes of word 2: nothing written at 0x008.
        fill_words(4);
        got_a.delete();
        got_d.delete();
        pulse_start();
        send_word(32'd4, 1);
        send_word(words_q[0], 1);
        send_word(words_q[1], 1);
        send_byte(words_q[2][7:0], 1);
        send_byte(words_q[2][15:8], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_s_ready", bus.s_ready, 1'b0);
        check("mid_rst_w_enb", bus.w_enb, 1'b0);
        check("mid_rst_byte_enb", bus.byte_enb, 4'b0000);
        check("mid_rst_w_addr", bus.w_addr, 0);
        check("mid_rst_w_dat", bus.w_dat, 32'd0);
        check("mid_rst_core_stall", core_stall, 1'b1);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_error", error, 1'b0);
        check("mid_rst_words_written", words_written, 0);
        repeat (4) tick();
        compare_writes(2);
        fill_words(2);
        run_load(32'd2, 1, 1'b0);

        // Randomized loads of assorted lengths and gap patterns.
        for (int k = 0; k < 6; k++) begin
            int n;
            n = int'($urandom_range(12, 1));
            fill_words(n);
            run_load(32'(n), int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end

        // Full-capacity image ends at the top word address.
        fill_words(MAX_WORDS);
        run_load(32'(MAX_WORDS), 0, 1'b0);
        if (got_a.size() > 0) check("full_last_addr", got_a[got_a.size() - 1], 32'((1 << AW) - 4));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
